// File: rtl/playback_reader_if.sv
// Sample-memory read port between the playback reader (master) and the sample RAM (slave).
// Read data returns one cycle after mem_en.
interface playback_reader_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_en,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_en,
    output mem_rdata
  );
endinterface

// File: rtl/playback_reader.sv
// Streams recorded samples out of a synchronous sample RAM, one per sample_tick,
// with optional looping and a done pulse at the end of a one-shot playback.
module playback_reader #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                play,
  input  logic                stop,
  input  logic                loop,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                sample_tick,
  playback_reader_if.master   mem,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_TICK,
    READ,
    CAPTURE
  } state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [ADDR_W-1:0] end_q, end_q_d;
  logic              capture;
  logic              done_d;
  logic              last;

  // end_q is never zero while busy, so end_q-1 cannot wrap
  assign last = (addr == (end_q - ONE));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  // stop overrides everything, including a capture already under way
  always_comb begin
    state_d = state;
    addr_d  = addr;
    end_q_d = end_q;
    capture = 1'b0;
    done_d  = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (play) begin
            if (end_addr == '0) begin
              done_d = 1'b1;
            end else begin
              end_q_d = end_addr;
              addr_d  = '0;
              state_d = WAIT_TICK;
            end
          end
        end
        WAIT_TICK: begin
          if (sample_tick) state_d = READ;
        end
        READ: begin
          state_d = CAPTURE;
        end
        CAPTURE: begin
          capture = 1'b1;
          if (!last) begin
            addr_d  = addr + ONE;
            state_d = WAIT_TICK;
          end else if (loop) begin
            addr_d  = '0;
            state_d = WAIT_TICK;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr         <= '0;
      end_q        <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      addr         <= addr_d;
      end_q        <= end_q_d;
      sample_valid <= capture;
      done         <= done_d;
      if (capture) sample_out <= mem.mem_rdata;
    end
  end

  assign mem.mem_addr = addr;
  assign mem.mem_en   = (state == READ);
  assign busy         = (state != IDLE);

endmodule

// File: tb/tb_playback_reader.sv
// Bench for playback_reader: table-driven playback scenarios, hand-written stop/reset
// sequences and a randomized run, all checked cycle by cycle against a timestamp model.
module tb_playback_reader;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              play = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [ADDR_W-1:0] end_addr = '0;
  logic              sample_tick = 1'b0;
  logic [DATA_W-1:0] sample_out;
  logic              sample_valid;
  logic              busy;
  logic              done;

  playback_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mif ();

  playback_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .play         (play),
    .stop         (stop),
    .loop         (loop),
    .end_addr     (end_addr),
    .sample_tick  (sample_tick),
    .mem          (mif.master),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] mem_data [16];

  always @(posedge clk) begin
    if (mif.mem_en) mif.mem_rdata <= mem_data[mif.mem_addr];
  end

  // Reference model: a playback session plus the timestamp of the tick being served.
  int m_active = 0, m_addr = 0, m_end = 0, m_pend = -1, m_cyc = 0;
  int e_busy = 0, e_men = 0, e_addr = 0, e_valid = 0, e_out = 0, e_done = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_addr = 0; m_end = 0; m_pend = -1; m_cyc = 0;
      e_busy = 0; e_men = 0; e_addr = 0; e_valid = 0; e_out = 0; e_done = 0;
    end else begin
      e_valid = 0;
      e_done  = 0;
      if (stop) begin
        m_active = 0;
        m_pend   = -1;
      end else if (m_active == 0) begin
        if (play) begin
          if (end_addr == 0) e_done = 1;
          else begin
            m_active = 1;
            m_end    = int'(end_addr);
            m_addr   = 0;
          end
        end
      end else if (m_pend >= 0) begin
        if (m_cyc == m_pend + 2) begin
          e_valid = 1;
          e_out   = int'(mem_data[m_addr]);
          m_pend  = -1;
          if (m_addr == m_end - 1) begin
            if (loop) m_addr = 0;
            else begin
              m_active = 0;
              e_done   = 1;
            end
          end else begin
            m_addr = m_addr + 1;
          end
        end
      end else if (sample_tick) begin
        m_pend = m_cyc;
      end
      e_men  = (m_pend == m_cyc) ? 1 : 0;
      e_busy = m_active;
      e_addr = m_addr;
      m_cyc  = m_cyc + 1;
    end
  end

  int vectors = 0, miscompares = 0;
  int obs_valid = 0, obs_done = 0, obs_men = 0;
  bit seq_on = 0;
  int seq_mod = 1, seq_idx = 0;

  typedef struct {
    int end_a;
    bit lp;
    int ticks;
    int gap;
    int exp_valid;
    int exp_done;
    int exp_men;
    bit exp_busy;
  } vec_t;

  vec_t tbl [5];

  task automatic cmp(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    cmp("busy", int'(busy), e_busy);
    cmp("mem_en", int'(mif.mem_en), e_men);
    cmp("mem_addr", int'(mif.mem_addr), e_addr);
    cmp("sample_valid", int'(sample_valid), e_valid);
    cmp("sample_out", int'(sample_out), e_out);
    cmp("done", int'(done), e_done);
    if (sample_valid) obs_valid++;
    if (done) obs_done++;
    if (mif.mem_en) begin
      obs_men++;
      if (seq_on) begin
        cmp("addr_seq", int'(mif.mem_addr), seq_idx % seq_mod);
        seq_idx++;
      end
    end
  endtask

  task automatic applyStimulus(input bit p, input bit s, input bit t);
    @(negedge clk);
    checkOutput();
    play        = p;
    stop        = s;
    sample_tick = t;
  endtask

  task automatic runScenario(input vec_t v);
    int v0, d0, m0;
    applyStimulus(0, 1, 0);
    loop     = v.lp;
    end_addr = ADDR_W'(v.end_a);
    v0 = obs_valid; d0 = obs_done; m0 = obs_men;
    seq_on  = 1;
    seq_mod = (v.end_a == 0) ? 1 : v.end_a;
    seq_idx = 0;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    // the latched length must survive end_addr wandering during playback
    end_addr = ADDR_W'($urandom_range(0, 15));
    for (int i = 0; i < v.ticks; i++) begin
      applyStimulus(0, 0, 1);
      for (int g = 1; g < v.gap; g++) applyStimulus(0, 0, 0);
    end
    repeat (8) applyStimulus(0, 0, 0);
    seq_on = 0;
    cmp("scn_valid_count", obs_valid - v0, v.exp_valid);
    cmp("scn_done_count", obs_done - d0, v.exp_done);
    cmp("scn_mem_en_count", obs_men - m0, v.exp_men);
    cmp("scn_busy_end", int'(busy), int'(v.exp_busy));
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int v0;
    tbl[0] = '{4, 1'b0, 4, 10, 4, 1, 4, 1'b0};
    tbl[1] = '{3, 1'b1, 7, 10, 7, 0, 7, 1'b1};
    tbl[2] = '{0, 1'b0, 0, 10, 0, 1, 0, 1'b0};
    tbl[3] = '{2, 1'b0, 4, 2, 2, 1, 2, 1'b0};
    tbl[4] = '{15, 1'b0, 15, 4, 15, 1, 15, 1'b0};
    for (int i = 0; i < 16; i++) mem_data[i] = DATA_W'($urandom_range(1, 65535));

    #1 reset_n = 1'b0;
    #1;
    cmp("rst_busy", int'(busy), 0);
    cmp("rst_mem_en", int'(mif.mem_en), 0);
    cmp("rst_mem_addr", int'(mif.mem_addr), 0);
    cmp("rst_sample_out", int'(sample_out), 0);
    cmp("rst_sample_valid", int'(sample_valid), 0);
    cmp("rst_done", int'(done), 0);
    repeat (2) applyStimulus(0, 0, 0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0);

    for (int i = 0; i < 5; i++) runScenario(tbl[i]);

    // stop in the READ cycle of address 2: sample 1 must stay on the output
    applyStimulus(0, 1, 0);
    loop = 1'b0;
    end_addr = 4'd8;
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1);
      repeat (3) applyStimulus(0, 0, 0);
    end
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 0);
    cmp("stop_mem_addr", int'(mif.mem_addr), 2);
    cmp("stop_mem_en", int'(mif.mem_en), 1);
    v0 = obs_valid;
    repeat (6) applyStimulus(0, 0, 0);
    cmp("stop_no_valid", obs_valid - v0, 0);
    cmp("stop_hold_sample", int'(sample_out), int'(mem_data[1]));
    cmp("stop_idle", int'(busy), 0);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) loop = ~loop;
      end_addr = ADDR_W'($urandom_range(0, 15));
      applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 79) == 0,
                    $urandom_range(0, 3) == 0);
    end

    // reset in the CAPTURE cycle, then a fresh playback from address 0
    applyStimulus(0, 1, 0);
    loop = 1'b1;
    end_addr = 4'd5;
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 0, 0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    cmp("arst_busy", int'(busy), 0);
    cmp("arst_mem_en", int'(mif.mem_en), 0);
    cmp("arst_mem_addr", int'(mif.mem_addr), 0);
    cmp("arst_sample_out", int'(sample_out), 0);
    cmp("arst_sample_valid", int'(sample_valid), 0);
    cmp("arst_done", int'(done), 0);
    repeat (2) applyStimulus(0, 0, 0);
    seq_on  = 1;
    seq_mod = 5;
    seq_idx = 0;
    v0 = obs_valid;
    applyStimulus(1, 0, 0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    repeat (5) applyStimulus(0, 0, 0);
    seq_on = 0;
    cmp("arst_restart_addr_count", seq_idx, 1);
    cmp("arst_restart_valid", obs_valid - v0, 1);
    cmp("arst_restart_sample", int'(sample_out), int'(mem_data[0]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/playback_reader.md
PLAYBACK_READER -- requirements
Module: playback_reader

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 17, meaning the sample-memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the audio sample width.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge only.
REQ-004 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port play, input, 1 bit: one-cycle start request.
REQ-006 Port stop, input, 1 bit: one-cycle abort request.
REQ-007 Port loop, input, 1 bit: level; when high, playback restarts at address 0 after the last sample.
REQ-008 Port end_addr, input, ADDR_W bits: count of recorded samples; playback reads addresses 0 to end_addr-1.
REQ-009 Port sample_tick, input, 1 bit: one-cycle strobe at the audio sample rate.
REQ-010 Port mem_addr, output, ADDR_W bits: read address to the sample memory.
REQ-011 Port mem_en, output, 1 bit: memory read enable.
REQ-012 Port mem_rdata, input, DATA_W bits: memory read data, valid exactly one cycle after mem_en is high.
REQ-013 Port sample_out, output, DATA_W bits: registered current playback sample.
REQ-014 Port sample_valid, output, 1 bit: one-cycle pulse when sample_out updates.
REQ-015 Port busy, output, 1 bit: high in every state except IDLE.
REQ-016 Port done, output, 1 bit: one-cycle pulse at normal end of a non-looping playback.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_TICK, READ and CAPTURE.
REQ-018 In IDLE with play=1, stop=0 and end_addr!=0, the block SHALL latch end_addr into end_q, set the address register to 0 and enter WAIT_TICK.
REQ-019 In IDLE with play=1, stop=0 and end_addr==0, the block SHALL pulse done in the next cycle and remain in IDLE.
REQ-020 In WAIT_TICK, sample_tick=1 SHALL move the FSM to READ; otherwise it stays in WAIT_TICK.
REQ-021 mem_en SHALL be high only in READ, and mem_addr SHALL equal the address register in every state.
REQ-022 READ SHALL always advance to CAPTURE after one cycle.
REQ-023 In CAPTURE, sample_out SHALL be loaded from mem_rdata, so that sample_valid is high for exactly the following cycle.
REQ-024 Tick to sample_valid latency SHALL be 3 cycles: tick seen in cycle T, mem_en high in T+1, capture in T+2, sample_valid high in T+3.
REQ-025 In CAPTURE, if address != end_q-1, the address SHALL increment by 1 and the FSM SHALL enter WAIT_TICK.
REQ-026 In CAPTURE, if address == end_q-1 and loop=1, the address SHALL become 0 and the FSM SHALL enter WAIT_TICK, with no done pulse.
REQ-027 In CAPTURE, if address == end_q-1 and loop=0, done SHALL pulse in the following cycle and the FSM SHALL enter IDLE with the address held.
REQ-028 sample_tick in READ or CAPTURE SHALL be ignored and not queued.
REQ-029 stop=1 in any state SHALL force IDLE on the next edge, with no done pulse, no sample_valid, and sample_out unchanged.
REQ-030 If stop and play are high together in IDLE, stop SHALL win and no playback starts.
REQ-031 play while busy SHALL be ignored, and end_addr changes while busy SHALL have no effect.
REQ-032 The address SHALL never exceed end_q-1, and end_addr = 2^ADDR_W-1 SHALL play every address without overflow.
REQ-033 sample_out SHALL hold its last value between samples and after playback ends.

Reset
REQ-034 With reset_n low, the block SHALL immediately enter IDLE, with the address, end_q, sample_out, mem_addr, mem_en, sample_valid, busy and done all 0.
REQ-035 Reset asserted mid-playback SHALL abort the playback with no done pulse, and play is accepted from the first edge after reset_n rises.

Verification
REQ-036 end_addr=4, loop=0, play, tick every 10 cycles -> mem_addr 0,1,2,3; sample_valid 3 cycles after each tick with sample_out = memory contents; done pulses once; busy drops.
REQ-037 end_addr=3, loop=1, 7 ticks -> address sequence 0,1,2,0,1,2,0; done never pulses; busy stays high.
REQ-038 end_addr=0, play -> done pulses in the next cycle; busy never rises; mem_en never rises.
REQ-039 stop at the cycle of mem_en with address 2 -> IDLE next cycle; no sample_valid; sample_out holds sample 1.
REQ-040 Ticks 2 cycles apart -> the second tick is ignored, and only one sample_valid occurs per accepted tick.
REQ-041 reset_n low during CAPTURE -> all outputs 0 asynchronously; play after release starts at address 0.
